// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for three snooping processors sharing one bus.
//   A transaction walks IDLE -> GRANT -> [SNOOP -> [MEM]] -> DONE -> IDLE:
//   the winner's message is latched at the end of GRANT, broadcast with a
//   one-cycle bus_valid strobe in SNOOP, and read/write misses then wait in
//   MEM for mem_ready (bounded by MEM_TIMEOUT).
//
// Ports
//   clock        in   system clock, all state on the rising edge
//   reset        in   synchronous, active-high
//   req[2:0]     in   level requests, bit0=p1, bit1=p2, bit2=p3
//   msg1..msg3   in   message offered by each processor ([8:7] opcode)
//   mem_ready    in   memory finished the current miss service
//   grant[2:0]   out  one-hot grant, held GRANT..DONE
//   bus_out      out  latched message from SNOOP onward, 0 otherwise
//   bus_valid    out  one-cycle snoop strobe
//   mem_req      out  high throughout MEM
//   busy         out  high in every state except IDLE
//   timeout_err  out  one-cycle pulse when a MEM wait is abandoned
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MEM_TIMEOUT = 15,
    parameter int MSG_W       = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       req,
    input  logic [MSG_W-1:0] msg1,
    input  logic [MSG_W-1:0] msg2,
    input  logic [MSG_W-1:0] msg3,
    input  logic             mem_ready,
    output logic [2:0]       grant,
    output logic [MSG_W-1:0] bus_out,
    output logic             bus_valid,
    output logic             mem_req,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    localparam logic [1:0] OP_NULL = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SNOOP,
        S_MEM,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;        // highest-priority requester, 0..2
    logic [1:0]       winner_q, winner_d;  // current grant holder, 0..2
    logic [MSG_W-1:0] msg_q, msg_d;        // latched winner message
    logic [CNT_W-1:0] cnt_q, cnt_d;        // MEM wait counter

    logic [MSG_W-1:0] winner_msg;

    // First requester found when searching ptr, ptr+1, ptr+2 (mod 3).
    // Searching from the far end lets the nearest hit overwrite the rest.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] pick;
        int         idx;
        pick = p;
        for (int i = 2; i >= 0; i--) begin
            idx = (int'(p) + i) % 3;
            if (r[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        case (winner_q)
            2'd0:    winner_msg = msg1;
            2'd1:    winner_msg = msg2;
            default: winner_msg = msg3;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        msg_d       = msg_q;
        cnt_d       = '0;
        grant       = 3'b000;
        bus_out     = '0;
        bus_valid   = 1'b0;
        mem_req     = 1'b0;
        busy        = (state_q != S_IDLE);
        timeout_err = 1'b0;

        if (state_q != S_IDLE) grant[winner_q] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    winner_d = rr_pick(req, ptr_q);
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                msg_d   = winner_msg;
                state_d = (winner_msg[MSG_W-1 -: 2] == OP_NULL) ? S_DONE : S_SNOOP;
            end
            S_SNOOP: begin
                bus_out = msg_q;
                // Gated so an edge that resets the bus never carries a strobe.
                bus_valid = ~reset;
                state_d   = (msg_q[MSG_W-1 -: 2] == OP_INV) ? S_DONE : S_MEM;
            end
            S_MEM: begin
                bus_out = msg_q;
                mem_req = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // mem_ready has priority over an expiring counter.
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_VAL) begin
                    timeout_err = ~reset;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                bus_out = msg_q;
                ptr_d   = (winner_q == 2'd2) ? 2'd0 : winner_q + 2'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the message register is reset as well, so no stale data
            // can ever surface on bus_out after a reset.
            state_q  <= S_IDLE;
            ptr_q    <= 2'd0;
            winner_q <= 2'd0;
            msg_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            msg_q    <= msg_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Transaction-level reference: for each request the bench works out the
//   round-robin winner from its own pointer, then derives the expected
//   per-cycle timeline (grant, snoop strobe, MEM window, timeout) from the
//   opcode and the chosen memory latency, and compares every output on every
//   cycle of the transaction.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int MEM_TIMEOUT = 15;
    localparam int MSG_W       = 9;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       req;
    logic [MSG_W-1:0] msg1, msg2, msg3;
    logic             mem_ready;
    logic [2:0]       grant;
    logic [MSG_W-1:0] bus_out;
    logic             bus_valid, mem_req, busy, timeout_err;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;   // model round-robin pointer, 0=p1
    int txn   = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.MEM_TIMEOUT(MEM_TIMEOUT), .MSG_W(MSG_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .msg1        (msg1),
        .msg2        (msg2),
        .msg3        (msg3),
        .mem_ready   (mem_ready),
        .grant       (grant),
        .bus_out     (bus_out),
        .bus_valid   (bus_valid),
        .mem_req     (mem_req),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string where);
        check({where, ".busy"},        32'(busy),        32'd0);
        check({where, ".grant"},       32'(grant),       32'd0);
        check({where, ".bus_out"},     32'(bus_out),     32'd0);
        check({where, ".bus_valid"},   32'(bus_valid),   32'd0);
        check({where, ".mem_req"},     32'(mem_req),     32'd0);
        check({where, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // following IDLE cycle. lat = cycles after MEM entry until mem_ready
    // (beyond MEM_TIMEOUT means never). abort_k = cycle to assert reset, -1 none.
    task automatic run_txn(input logic [2:0] r, input logic [8:0] m0, input logic [8:0] m1,
                           input logic [8:0] m2, input int lat, input int abort_k,
                           input bit jitter);
        logic [8:0] msgs [3];
        logic [8:0] exp_msg;
        int         w, op, mem_cycles, done_k;
        bit         tmo, in_mem, aborted;
        string      t;

        msgs[0] = m0; msgs[1] = m1; msgs[2] = m2;
        w = -1;
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (ptr_m + i) % 3;
            if (w < 0 && r[idx]) w = idx;
        end
        exp_msg    = msgs[w];
        op         = int'(exp_msg[8:7]);
        tmo        = (lat > MEM_TIMEOUT);
        mem_cycles = tmo ? MEM_TIMEOUT + 1 : lat + 1;
        done_k     = (op == 0) ? 1 : (op == 3) ? 2 : 2 + mem_cycles;
        aborted    = 1'b0;

        req = r; msg1 = m0; msg2 = m1; msg3 = m2;
        mem_ready = 1'($urandom % 2);
        #1;
        check_quiet($sformatf("t%0d.idle", txn));

        for (int k = 0; k <= done_k; k++) begin
            @(posedge clock); #1;
            in_mem    = (op == 1 || op == 2) && k >= 2 && k < 2 + mem_cycles;
            mem_ready = in_mem ? (k - 2 == lat) : 1'($urandom % 2);
            if (jitter) begin
                req = 3'($urandom % 8);
                if (k >= 1) begin
                    msg1 = 9'($urandom); msg2 = 9'($urandom); msg3 = 9'($urandom);
                end
            end
            if (k == abort_k) reset = 1'b1;
            #1;
            t = $sformatf("t%0d.k%0d", txn, k);
            check({t, ".busy"},      32'(busy),      32'd1);
            check({t, ".grant"},     32'(grant),     32'(3'b001 << w));
            check({t, ".bus_valid"}, 32'(bus_valid), 32'(k == 1 && op != 0 && k != abort_k));
            check({t, ".bus_out"},   32'(bus_out),   (k == 0) ? 32'd0 : 32'(exp_msg));
            check({t, ".mem_req"},   32'(mem_req),   32'(in_mem));
            check({t, ".timeout"},   32'(timeout_err),
                  32'(tmo && k == 2 + MEM_TIMEOUT && k != abort_k));
            if (k == abort_k) begin
                aborted = 1'b1;
                break;
            end
        end

        @(posedge clock); #1;
        if (aborted) begin
            reset = 1'b0;
            ptr_m = 0;
            #1;
            check_quiet($sformatf("t%0d.after_reset", txn));
        end else begin
            ptr_m = (w + 1) % 3;
        end
        req = 3'b000;
        txn++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req = 3'b000;
            mem_ready = 1'($urandom % 2);
            @(posedge clock); #1;
            check_quiet($sformatf("gap%0d_%0d", txn, i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 3'b111; mem_ready = 1'b1;
        msg1 = 9'h1ff; msg2 = 9'h1ff; msg3 = 9'h1ff;
        @(posedge clock); @(posedge clock); #1;
        check_quiet("reset");
        reset = 1'b0; req = 3'b000; mem_ready = 1'b0;

        // Continuous requests, invalidates: grants rotate p1, p2, p3, p1.
        for (int i = 0; i < 4; i++)
            run_txn(3'b111, 9'h180 | 9'(i), 9'h190 | 9'(i), 9'h1a0 | 9'(i), 0, -1, 1'b0);

        // p2 write miss, memory answers 2 cycles after MEM entry.
        run_txn(3'b010, 9'h000, 9'b10_0000101, 9'h000, 2, -1, 1'b0);
        // p1 read miss, memory never answers -> timeout, pointer moves to p2.
        run_txn(3'b001, 9'h0a5, 9'h000, 9'h000, 99, -1, 1'b0);
        // p3 null opcode -> GRANT then DONE, pointer wraps to p1.
        run_txn(3'b100, 9'h000, 9'h000, 9'h03c, 0, -1, 1'b0);
        run_txn(3'b111, 9'h181, 9'h182, 9'h183, 0, -1, 1'b0);
        // mem_ready on the expiring cycle wins over the timeout.
        run_txn(3'b001, 9'h111, 9'h000, 9'h000, MEM_TIMEOUT, -1, 1'b0);
        // Reset during MEM, then p2/p3 requesting: p2 wins from pointer p1.
        run_txn(3'b001, 9'h0f0, 9'h000, 9'h000, 99, 5, 1'b0);
        run_txn(3'b110, 9'h000, 9'h1c2, 9'h1c3, 0, -1, 1'b0);
        // Reset on the very cycle the wait would expire: no timeout pulse.
        run_txn(3'b010, 9'h000, 9'h0aa, 9'h000, 99, 2 + MEM_TIMEOUT, 1'b0);

        for (int i = 0; i < 30; i++) begin
            idle_cycles($urandom_range(0, 2));
            run_txn(3'($urandom_range(1, 7)), 9'($urandom), 9'($urandom), 9'($urandom),
                    $urandom_range(0, 20), -1, 1'b1);
        end
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
